// File: rtl/spi_master_fab.sv
// spi_master_fab: fabric SPI master with CPOL/CPHA modes,
// runtime clock divider, N selects and select hold for bursts.
module spi_master_fab #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 2,
  parameter int SEL_W  = 1,
  parameter int DIV_W  = 8
) (
  input  logic              FAB_CLK,
  input  logic              FAB_RESET,
  input  logic              START,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic [SEL_W-1:0]  SS_SEL,
  input  logic              HOLD_SS,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic [DIV_W-1:0]  CLK_DIV,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              SPI_CLK,
  output logic              SPI_DO,
  input  logic              SPI_DI,
  output logic [NUM_SS-1:0] SPI_SS_N
);

  localparam int EW = $clog2(2*DATA_W) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD,
    S_END
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [EW-1:0]     r_edge;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rxd;
  logic [SEL_W-1:0]  r_sel;
  logic [NUM_SS-1:0] r_ss_n;
  logic              r_hold;
  logic              r_held;
  logic              r_cpha;
  logic              r_clk;
  logic              r_do;

  logic              w_accept;
  logic              w_skip;
  logic              w_tick;
  logic              w_busy_st;
  logic              w_xfer_tick;
  logic              w_hold_done;
  logic [EW-1:0]     w_edge;
  logic              w_odd;
  logic              w_last;
  logic [NUM_SS-1:0] w_ss_dec;

  assign w_busy_st = (r_state == S_SETUP) ||
                     (r_state == S_XFER)  ||
                     (r_state == S_HOLD);
  assign w_accept  = START &&
                     ((r_state == S_IDLE) ||
                      (r_state == S_END));
  assign w_skip    = r_held && (SS_SEL == r_sel);
  assign w_tick    = (r_cnt == r_div);
  assign w_edge    = r_edge + EW'(1);
  assign w_odd     = w_edge[0];
  assign w_last    = (w_edge == LAST_EDGE);

  assign w_xfer_tick = (r_state == S_XFER) && w_tick;
  assign w_hold_done = (r_state == S_HOLD) && w_tick;

  // Out-of-range indices match no bit, so no select asserts.
  for (genvar g = 0; g < NUM_SS; g++) begin : g_dec
    assign w_ss_dec[g] = (SS_SEL != SEL_W'(g));
  end

  assign SPI_CLK  = r_clk;
  assign SPI_DO   = r_do;
  assign SPI_SS_N = r_ss_n;
  assign RX_DATA  = r_rxd;

  // State register.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Next-state: a held select to the same slave skips SETUP.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_END: begin
        if (w_accept) w_next = w_skip ? S_XFER : S_SETUP;
        else          w_next = S_IDLE;
      end
      S_SETUP: if (w_tick) w_next = S_XFER;
      S_XFER:  if (w_tick && w_last) w_next = S_HOLD;
      S_HOLD:  if (w_tick) w_next = S_END;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    unique case (r_state)
      S_SETUP, S_XFER, S_HOLD: BUSY = 1'b1;
      S_END:                   DONE = 1'b1;
      default: ;
    endcase
  end

  // Half-period counter; expires after CLK_DIV+1 cycles.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      r_cnt <= '0;
    end else if (w_accept || w_tick) begin
      r_cnt <= '0;
    end else if (w_busy_st) begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  // SCLK edge counter, sized so it stops at 2*DATA_W.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET)        r_edge <= '0;
    else if (w_accept)    r_edge <= '0;
    else if (w_xfer_tick) r_edge <= w_edge;
  end

  // Per-word configuration captured on an accepted START.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      r_div  <= '0;
      r_sel  <= '0;
      r_hold <= 1'b0;
      r_cpha <= 1'b0;
    end else if (w_accept) begin
      r_div  <= CLK_DIV;
      r_sel  <= SS_SEL;
      r_hold <= HOLD_SS;
      r_cpha <= CPHA;
    end
  end

  // Serial engine: clock toggle, drive and sample on edges.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      r_tx  <= '0;
      r_rx  <= '0;
      r_clk <= 1'b0;
      r_do  <= 1'b0;
    end else if (w_accept) begin
      r_tx  <= TX_DATA;
      r_clk <= CPOL;
      if (!CPHA) r_do <= TX_DATA[DATA_W-1];
    end else if (w_xfer_tick) begin
      r_clk <= ~r_clk;
      if (w_odd ^ r_cpha) begin
        r_rx <= {r_rx[DATA_W-2:0], SPI_DI};
      end else if (r_cpha) begin
        r_do <= r_tx[DATA_W-1];
        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end else if (!w_last) begin
        r_do <= r_tx[DATA_W-2];
        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Received word becomes visible in the DONE cycle.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET)        r_rxd <= '0;
    else if (w_hold_done) r_rxd <= r_rx;
  end

  // Slave selects and the held-select flag.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      r_ss_n <= '1;
      r_held <= 1'b0;
    end else if (w_accept) begin
      r_ss_n <= w_ss_dec;
      r_held <= 1'b0;
    end else if (w_hold_done) begin
      if (r_hold) r_held <= 1'b1;
      else        r_ss_n <= '1;
    end
  end

endmodule

// File: tb/tb_spi_master_fab.sv
// tb_spi_master_fab: directed vector table plus hand-written
// burst, select switch, ignored START and reset sequences.
module tb_spi_master_fab;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx = 8'h00;
  logic       sel = 1'b0;
  logic       hold = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] div = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] rx;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [1:0] ss_n;

  logic       loop_en = 1'b1;
  logic [7:0] s_sr = 8'h00;
  logic       ss_q = 1'b1;
  logic       sclk_q = 1'b0;
  logic [7:0] do_bits = 8'h00;

  logic [1:0] ss_tr [0:511];
  logic       clk_tr [0:511];

  int n_cmp = 0;
  int n_bad = 0;

  spi_master_fab #(
    .DATA_W(8),
    .NUM_SS(2),
    .SEL_W(1),
    .DIV_W(8)
  ) dut (
    .FAB_CLK  (clk),
    .FAB_RESET(rst),
    .START    (start),
    .TX_DATA  (tx),
    .SS_SEL   (sel),
    .HOLD_SS  (hold),
    .CPOL     (cpol),
    .CPHA     (cpha),
    .CLK_DIV  (div),
    .BUSY     (busy),
    .DONE     (done),
    .RX_DATA  (rx),
    .SPI_CLK  (sclk),
    .SPI_DO   (mosi),
    .SPI_DI   (miso),
    .SPI_SS_N (ss_n)
  );

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : s_sr[7];

  // Mode-0 slave on select 0: loads 0x3C, shifts on falling SCLK.
  always @(ss_n[0] or sclk) begin
    if (ss_q && !ss_n[0])
      s_sr = 8'h3C;
    else if (sclk_q && !sclk && !ss_n[0])
      s_sr = {s_sr[6:0], 1'b0};
    ss_q = ss_n[0];
    sclk_q = sclk;
  end

  // MOSI seen by a mode-0 slave on rising SCLK.
  always @(posedge sclk) do_bits = {do_bits[6:0], mosi};

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic start_word(input logic p,
                            input logic h,
                            input logic [7:0] d,
                            input logic s,
                            input logic hs,
                            input logic [7:0] t);
    cpol = p;
    cpha = h;
    div = d;
    sel = s;
    hold = hs;
    tx = t;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    ss_tr[1] = ss_n;
    clk_tr[1] = sclk;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      ss_tr[lat] = ss_n;
      clk_tr[lat] = sclk;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no DONE in %0d cycles", lat);
    end
  endtask

  typedef struct {
    logic       pol;
    logic       pha;
    logic [7:0] dv;
    logic       sl;
    logic       lpb;
    logic [7:0] txd;
    logic [7:0] rxd;
    int         lat;
    logic [1:0] ss_on;
    logic       chk_do;
  } vec_t;

  vec_t vt [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int h;
    int runs;
    int badw;
    int w;
    int bad;
    int nd;
    int first;
    logic [7:0] rx_at;

    vt[0] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0,
              8'hA5, 8'h3C, 19, 2'b10, 1'b1};
    vt[1] = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b1,
              8'h81, 8'h81, 73, 2'b10, 1'b0};
    vt[2] = '{1'b1, 1'b0, 8'd3, 1'b0, 1'b1,
              8'h81, 8'h81, 73, 2'b10, 1'b0};
    vt[3] = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b1,
              8'h81, 8'h81, 73, 2'b10, 1'b0};
    vt[4] = '{1'b1, 1'b1, 8'd1, 1'b1, 1'b1,
              8'h5A, 8'h5A, 37, 2'b01, 1'b0};

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst rx", 32'(rx), 32'h00);
    check("rst sclk", 32'(sclk), 32'd0);
    check("rst mosi", 32'(mosi), 32'd0);
    check("rst ss_n", 32'(ss_n), 32'h3);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      loop_en = vt[i].lpb;
      start_word(vt[i].pol, vt[i].pha, vt[i].dv,
                 vt[i].sl, 1'b0, vt[i].txd);
      wait_done(lat);
      check($sformatf("v%0d latency", i),
            32'(lat), 32'(vt[i].lat));
      check($sformatf("v%0d rx", i),
            32'(rx), 32'(vt[i].rxd));
      bad = 0;
      for (int k = 1; k < lat; k++)
        if (ss_tr[k] !== vt[i].ss_on) bad++;
      check($sformatf("v%0d ss during", i),
            32'(bad), 32'd0);
      check($sformatf("v%0d ss at done", i),
            32'(ss_tr[lat]), 32'h3);
      h = int'(vt[i].dv) + 1;
      runs = 0;
      badw = 0;
      w = 0;
      for (int k = 1; k <= lat; k++) begin
        if (clk_tr[k] !== vt[i].pol) begin
          w++;
        end else if (w != 0) begin
          runs++;
          if (w != h) badw++;
          w = 0;
        end
      end
      check($sformatf("v%0d sclk idle", i),
            32'({clk_tr[1], clk_tr[lat]}),
            32'({vt[i].pol, vt[i].pol}));
      check($sformatf("v%0d sclk pulses", i),
            32'(runs), 32'd8);
      check($sformatf("v%0d sclk width errs", i),
            32'(badw), 32'd0);
      if (vt[i].chk_do)
        check($sformatf("v%0d mosi bits", i),
              32'(do_bits), 32'hA5);
    end

    // Burst: held select, back-to-back START in DONE cycle.
    loop_en = 1'b1;
    @(negedge clk);
    start_word(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'h11);
    wait_done(lat);
    check("burst1 latency", 32'(lat), 32'd19);
    check("burst1 rx", 32'(rx), 32'h11);
    bad = 0;
    for (int k = 1; k <= lat; k++)
      if (ss_tr[k][0] !== 1'b0) bad++;
    start_word(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'h22);
    wait_done(lat);
    for (int k = 1; k < lat; k++)
      if (ss_tr[k][0] !== 1'b0) bad++;
    check("burst ss0 low", 32'(bad), 32'd0);
    check("burst2 latency", 32'(lat), 32'd18);
    check("burst2 rx", 32'(rx), 32'h22);
    check("burst ss after", 32'(ss_n), 32'h3);

    // Held select on slave 0, then a START to slave 1.
    @(negedge clk);
    start_word(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'h33);
    wait_done(lat);
    check("held rx", 32'(rx), 32'h33);
    repeat (3) @(posedge clk);
    #1;
    check("held idle ss", 32'(ss_n), 32'h2);
    check("held idle busy", 32'(busy), 32'd0);
    @(negedge clk);
    start_word(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'h44);
    check("switch ss", 32'(ss_n), 32'h1);
    wait_done(lat);
    check("switch latency", 32'(lat), 32'd19);
    check("switch rx", 32'(rx), 32'h44);
    check("switch ss end", 32'(ss_n), 32'h3);

    // START pulses while busy are ignored.
    @(negedge clk);
    start_word(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'h96);
    lat = 1;
    nd = 0;
    first = 0;
    bad = 0;
    rx_at = 8'h00;
    while (lat < 40) begin
      if (lat == 5 || lat == 9) begin
        tx = 8'h00;
        sel = 1'b1;
        hold = 1'b1;
        cpha = 1'b1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        nd++;
        if (first == 0) begin
          first = lat;
          rx_at = rx;
        end
      end else if (first == 0) begin
        if (rx !== 8'h44) bad++;
        if (ss_n !== 2'b10) bad++;
      end
    end
    start = 1'b0;
    check("ignore done count", 32'(nd), 32'd1);
    check("ignore latency", 32'(first), 32'd19);
    check("ignore rx", 32'(rx_at), 32'h96);
    check("ignore rx/ss held", 32'(bad), 32'd0);
    check("ignore busy end", 32'(busy), 32'd0);

    // Reset at SCLK edge 7 of a mode-0 transfer.
    @(negedge clk);
    start_word(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'h5A);
    repeat (8) @(posedge clk);
    #1;
    check("pre-reset sclk", 32'(sclk), 32'd1);
    check("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst rx", 32'(rx), 32'h00);
    check("arst sclk", 32'(sclk), 32'd0);
    check("arst mosi", 32'(mosi), 32'd0);
    check("arst ss_n", 32'(ss_n), 32'h3);
    nd = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("arst no done", 32'(nd), 32'd0);
    @(negedge clk);
    start_word(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'hFF);
    wait_done(lat);
    check("post-reset latency", 32'(lat), 32'd19);
    check("post-reset rx", 32'(rx), 32'hFF);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master_fab.md
Name: spi_master_fab

Overview:
- Parametrised fabric SPI master for the CC3000 link; successor to the fixed MSS SPI_0/SPI_1 pin-outs.
- Adds configurable word width, N slave selects, all four CPOL/CPHA modes, a runtime clock divider and chip-select hold for multi-word bursts.
- Driven by MSS fabric logic (APB wrapper or GPO); SPI pins route to top-level ports.

Parameters:
- DATA_W, 8, bits per word, ≥2; shifted MSB first.
- NUM_SS, 2, number of active-low slave selects, ≥1.
- SEL_W, 1, width of SS_SEL; must satisfy 2**SEL_W ≥ NUM_SS.
- DIV_W, 8, width of CLK_DIV.

Ports:
- FAB_CLK  in  1  fabric clock; all logic on rising edge.
- FAB_RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request; accepted only when BUSY=0.
- TX_DATA  in  DATA_W  word to send; latched on accepted START.
- SS_SEL  in  SEL_W  slave index; latched on START.
- HOLD_SS  in  1  1 = keep SS asserted after this word; latched on START.
- CPOL  in  1  idle SCLK level; latched on START.
- CPHA  in  1  0 = sample leading edge, 1 = sample trailing edge; latched on START.
- CLK_DIV  in  DIV_W  half-period H = CLK_DIV+1 FAB_CLK cycles; latched on START.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse at word end.
- RX_DATA  out  DATA_W  received word; updated in DONE cycle, held otherwise.
- SPI_CLK  out  1  serial clock.
- SPI_DO  out  1  MOSI.
- SPI_DI  in  1  MISO; used directly, no synchroniser; the divider guarantees settling.
- SPI_SS_N  out  NUM_SS  active-low selects; at most one low.

Behaviour:
- Reset, async: state IDLE, BUSY=0, DONE=0, RX_DATA=0, SPI_CLK=0, SPI_DO=0, SPI_SS_N all 1, held-select flag cleared.
- Reset mid-transfer aborts immediately. No partial RX_DATA update and no DONE.
- States: IDLE, SETUP, XFER, HOLD, END.
- IDLE:
  - SPI_CLK = latched CPOL (0 after reset).
  - Accepted START sets BUSY=1 on the next cycle.
  - SS_SEL<NUM_SS: that SPI_SS_N goes low on the same next cycle. SS_SEL≥NUM_SS: no select asserts, but the transfer still runs.
  - If a select is held from the previous word with the same SS_SEL, go to XFER (skip SETUP). Otherwise release any held select in that same cycle and go to SETUP.
- SETUP: H cycles. SPI_DO = TX MSB when CPHA=0.
- XFER: 2*DATA_W half-periods of H cycles; SPI_CLK toggles at each half-period boundary.
  - CPHA=0: sample SPI_DI on odd edges (1,3,…). Shift SPI_DO on even edges, except none after the last edge.
  - CPHA=1: drive the next bit on odd edges (first bit at edge 1). Sample on even edges.
  - Edge counter is log2(2*DATA_W)+1 bits and never wraps.
- HOLD: H cycles; SPI_CLK=CPOL.
- END: one cycle.
  - DONE=1, BUSY=0, RX_DATA ← shift register.
  - SPI_SS_N returns high unless HOLD_SS was latched, in which case the select stays low and the held flag is set.
  - START is accepted in the END cycle (back-to-back).
- Latency, START to DONE:
  - Fresh select: H*(2*DATA_W+2)+1 cycles.
  - Held select, same slave: H*(2*DATA_W+1)+1 cycles.
- START while BUSY=1 is ignored with no side effects. Inputs are only sampled on acceptance, so changes mid-transfer have no effect.
- A held select is released only by a START with HOLD_SS=0 completing, a START to a different SS_SEL, or reset.

Test Plan:
- DATA_W=8, CLK_DIV=0, mode 0, SS_SEL=0, TX=0xA5, slave echoes 0x3C:
  - SPI_DO bits 1,0,1,0,0,1,0,1; SPI_SS_N=2'b10 during transfer.
  - DONE at cycle 19 after START with RX_DATA=0x3C; SPI_SS_N=2'b11 in the DONE cycle.
- Modes 1, 2, 3 with CLK_DIV=3, TX=0x81, loopback DO→DI:
  - RX_DATA=0x81 each time.
  - SPI_CLK idles at CPOL.
  - Each level lasts 4 cycles.
  - DONE at cycle 73.
- Burst: START HOLD_SS=1 TX=0x11, then START in the DONE cycle with HOLD_SS=0 TX=0x22 to the same slave:
  - SPI_SS_N[0] stays low throughout.
  - Second DONE 18 cycles after its START (SETUP skipped).
  - SPI_SS_N[0] high after.
- Held select on slave 0, then START with SS_SEL=1:
  - SPI_SS_N[0] high the cycle after START; SPI_SS_N[1] low in that same cycle.
  - SETUP is executed.
- START pulsed at cycles 5 and 9 during a busy transfer: ignored; exactly one DONE; RX_DATA unchanged until it.
- FAB_RESET asserted mid-XFER, at edge 7:
  - All outputs return to reset values asynchronously; no DONE.
  - A later transfer with TX=0xFF returns RX_DATA=0xFF in loopback.
